// File: rtl/enc_pkg.sv
// Shared types and helpers for the 16-to-4 registered priority encoder.
package enc_pkg;

    localparam int unsigned N_IN   = 16;
    localparam int unsigned CODE_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        HOLD    = 2'd2,
        RELEASE = 2'd3
    } state_e;

    // True when more than one bit is set: clearing the lowest set bit leaves a nonzero value.
    function automatic logic popcnt_gt1(input logic [N_IN-1:0] v);
        return (v & (v - N_IN'(1))) != '0;
    endfunction

endpackage

// File: rtl/prio_enc16.sv
// Combinational highest-index encoder over 16 active-high request bits.
module prio_enc16
    import enc_pkg::*;
(
    input  logic [N_IN-1:0]   req_i,
    output logic [CODE_W-1:0] code_c,
    output logic              nz_c
);

    // Ascending scan so the highest set index wins; all-zero input encodes as 0.
    always_comb begin
        code_c = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (req_i[i]) begin
                code_c = CODE_W'(i);
            end
        end
        nz_c = |req_i;
    end

endmodule

// File: rtl/enc16_4_sync.sv
// Synchronised, debounced 16-to-4 priority encoder delivering one code per press
// through a VALID/ACK handshake.
module enc16_4_sync
    import enc_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 3
) (
    input  logic              CLOCK_50,
    input  logic              RST_N,
    input  logic [N_IN-1:0]   REQ_N,
    input  logic              ACK,
    output logic [CODE_W-1:0] CODE,
    output logic              VALID,
    output logic              MULTI,
    output logic              ANY
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [N_IN-1:0]   sync1_q, sync2_q;
    logic              any_q;
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CODE_W-1:0] cand_q, cand_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              valid_q, valid_d;
    logic              multi_q, multi_d;

    logic [N_IN-1:0]   act;
    logic [CODE_W-1:0] enc;
    logic              act_nz;

    assign act = ~sync2_q;

    prio_enc16 u_prio (
        .req_i  (act),
        .code_c (enc),
        .nz_c   (act_nz)
    );

    // any_q is loaded from the same sync1 value that sync2 takes, so it always equals |act.
    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q <= '1;
            sync2_q <= '1;
            any_q   <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
            cand_q  <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            multi_q <= 1'b0;
        end else begin
            sync1_q <= REQ_N;
            sync2_q <= sync1_q;
            any_q   <= |(~sync1_q);
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            multi_q <= multi_d;
        end
    end

    // Debounce / capture / release sequencing.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        code_d  = code_q;
        valid_d = valid_q;
        multi_d = multi_q;

        case (state_q)
            IDLE: begin
                if (act_nz) begin
                    state_d = SETTLE;
                    cand_d  = enc;
                    cnt_d   = '0;
                end
            end
            SETTLE: begin
                if (!act_nz) begin
                    state_d = IDLE;
                end else if (enc != cand_q) begin
                    cand_d = enc;
                    cnt_d  = '0;
                end else if (cnt_q == CNT_LAST) begin
                    code_d  = cand_q;
                    multi_d = popcnt_gt1(act);
                    valid_d = 1'b1;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                if (ACK) begin
                    valid_d = 1'b0;
                    cnt_d   = '0;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                // Any active line restarts the quiet period, so a held key cannot re-trigger.
                if (act_nz) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign CODE  = code_q;
    assign VALID = valid_q;
    assign MULTI = multi_q;
    assign ANY   = any_q;

endmodule

// File: tb/tb_enc16_4_sync.sv
// Directed bench for enc16_4_sync: capture table plus bounce, hold and reset sequences.
module tb_enc16_4_sync;

    logic        clk;
    logic        rst_n;
    logic [15:0] req_n;
    logic        ack;
    logic [3:0]  code;
    logic        valid;
    logic        multi;
    logic        any;

    int   total = 0;
    int   bad   = 0;
    logic seen;

    typedef struct {
        logic [15:0] req;
        logic [3:0]  code;
        logic        multi;
        string       name;
    } vec_t;

    vec_t vecs [9];

    enc16_4_sync dut (
        .CLOCK_50 (clk),
        .RST_N    (rst_n),
        .REQ_N    (req_n),
        .ACK      (ack),
        .CODE     (code),
        .VALID    (valid),
        .MULTI    (multi),
        .ANY      (any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Advance n cycles, remembering whether VALID was ever seen high.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            if (valid === 1'b1) seen = 1'b1;
        end
    endtask

    // Press from IDLE, expect capture exactly at edge 7, single-cycle ACK, then release back to IDLE.
    task automatic press_capture(input logic [15:0] req, input logic [3:0] c, input logic m,
                                 input string nm);
        req_n = req;
        repeat (6) tick();
        chk({nm, "_early"}, 16'(valid), 16'd0);
        tick();
        chk({nm, "_valid"}, 16'(valid), 16'd1);
        chk({nm, "_code"},  16'(code),  16'(c));
        chk({nm, "_multi"}, 16'(multi), 16'(m));
        chk({nm, "_any"},   16'(any),   16'd1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk({nm, "_acked"}, 16'(valid), 16'd0);
        req_n = 16'hFFFF;
        repeat (8) tick();
        chk({nm, "_idle_any"}, 16'(any), 16'd0);
    endtask

    initial begin
        vecs[0] = '{16'hFFFE, 4'h0, 1'b0, "line0"};
        vecs[1] = '{16'h7FF7, 4'hF, 1'b1, "l15_l3"};
        vecs[2] = '{16'hFFF7, 4'h3, 1'b0, "line3"};
        vecs[3] = '{16'h0000, 4'hF, 1'b1, "all"};
        vecs[4] = '{16'hFFDF, 4'h5, 1'b0, "line5"};
        vecs[5] = '{16'hEFFF, 4'hC, 1'b0, "line12"};
        vecs[6] = '{16'hFEFF, 4'h8, 1'b0, "line8"};
        vecs[7] = '{16'h5555, 4'hF, 1'b1, "odd"};
        vecs[8] = '{16'hFFFD, 4'h1, 1'b0, "line1"};

        rst_n = 1'b1;
        ack   = 1'b0;
        req_n = 16'hFFFF;
        seen  = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_code",  16'(code),  16'd0);
        chk("rst_valid", 16'(valid), 16'd0);
        chk("rst_any",   16'(any),   16'd0);
        repeat (3) tick();
        #2 rst_n = 1'b1;
        tick();

        // ANY latency, then asynchronous reset from HOLD with all lines active
        req_n = 16'h0000;
        tick();
        chk("any_edge1", 16'(any), 16'd0);
        tick();
        chk("any_edge2", 16'(any), 16'd1);
        repeat (5) tick();
        chk("all_valid", 16'(valid), 16'd1);
        chk("all_code",  16'(code),  16'hF);
        chk("all_multi", 16'(multi), 16'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_code",  16'(code),  16'd0);
        chk("arst_valid", 16'(valid), 16'd0);
        chk("arst_multi", 16'(multi), 16'd0);
        chk("arst_any",   16'(any),   16'd0);
        req_n = 16'hFFFF;
        tick();
        tick();
        #2 rst_n = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) begin
            press_capture(vecs[i].req, vecs[i].code, vecs[i].multi, vecs[i].name);
        end

        // Bounce on line 5: 2 on, 1 off, 3 on never completes a stable run
        seen  = 1'b0;
        req_n = 16'hFFDF; step(2);
        req_n = 16'hFFFF; step(1);
        req_n = 16'hFFDF; step(3);
        req_n = 16'hFFFF; step(10);
        chk("bounce5_novalid", 16'(seen), 16'd0);
        press_capture(16'hFFDF, 4'h5, 1'b0, "held5");

        seen  = 1'b0;
        req_n = 16'hFDFF; step(3);
        req_n = 16'hFFFF; step(12);
        chk("glitch9_novalid", 16'(seen), 16'd0);

        seen = 1'b0;
        ack  = 1'b1; step(3);
        ack  = 1'b0; step(1);
        chk("ack_idle_novalid", 16'(seen), 16'd0);

        // Frozen output while HOLD, then one VALID per press
        req_n = 16'hFFFB;
        repeat (7) tick();
        chk("hold_valid", 16'(valid), 16'd1);
        chk("hold_code",  16'(code),  16'h2);
        req_n = 16'hEFFB;
        repeat (5) tick();
        chk("hold_frozen_valid", 16'(valid), 16'd1);
        chk("hold_frozen_code",  16'(code),  16'h2);
        chk("hold_frozen_multi", 16'(multi), 16'd0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("hold_acked", 16'(valid), 16'd0);
        seen = 1'b0;
        step(4);
        ack = 1'b1; step(1);
        ack = 1'b0; step(7);
        chk("held_after_ack", 16'(seen), 16'd0);
        req_n = 16'hFFFF; step(2);
        req_n = 16'hEFFB; step(12);
        chk("short_release", 16'(seen), 16'd0);
        req_n = 16'hFFFF;
        repeat (8) tick();
        press_capture(16'hEFFB, 4'hC, 1'b1, "repress");

        // Reset while settling on line 4; CODE/MULTI still hold the previous capture
        req_n = 16'hFFEF;
        repeat (4) tick();
        chk("settle_any", 16'(any), 16'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("settle_rst_code",  16'(code),  16'd0);
        chk("settle_rst_multi", 16'(multi), 16'd0);
        chk("settle_rst_any",   16'(any),   16'd0);

        // Fresh capture of line 7 counted from reset release
        req_n = 16'hFF7F;
        tick();
        #2 rst_n = 1'b1;
        repeat (6) tick();
        chk("post_rst_early", 16'(valid), 16'd0);
        tick();
        chk("post_rst_valid", 16'(valid), 16'd1);
        chk("post_rst_code",  16'(code),  16'h7);
        chk("post_rst_multi", 16'(multi), 16'd0);

        #2 rst_n = 1'b0;
        #1;
        chk("hold_rst_valid", 16'(valid), 16'd0);
        chk("hold_rst_code",  16'(code),  16'd0);
        chk("hold_rst_any",   16'(any),   16'd0);
        req_n = 16'hFFFF;
        tick();
        #2 rst_n = 1'b1;
        tick();
        chk("final_valid", 16'(valid), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
